mdio_arbiter: RTL and testbench

Shares the single MDIO management controller between two requesters. Round-robin arbitration, Clause-22 frame assembly, controller handshake and a per-transaction timeout. Sits between requesters (host register port, link-status poller) and the MDIO controller's parallel interface (MDIO_START / T_DATA / MDIO_DONE / RD_DATA).

---
 rtl/mdio_pkg.sv | 40 ++++
 rtl/mdio_arbiter_if.sv | 31 +++
 rtl/rr_arb2.sv | 29 ++
 rtl/mdio_arbiter.sv | 111 +++++++++++
 tb/tb_mdio_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: Clause-22 frame codes, field positions and arbiter FSM states.
package mdio_pkg;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;
  localparam logic [1:0] TA_READ  = 2'b00;

  localparam int unsigned FR_ST_LSB   = 30;
  localparam int unsigned FR_OP_LSB   = 28;
  localparam int unsigned FR_PHY_LSB  = 23;
  localparam int unsigned FR_REG_LSB  = 18;
  localparam int unsigned FR_TA_LSB   = 16;
  localparam int unsigned FR_DATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } mdio_state_e;

  // Read frames carry zero in the data field; the PHY drives it after TA.
  function automatic logic [31:0] pack_frame(input logic        is_write,
                                             input logic [4:0]  phy,
                                             input logic [4:0]  regad,
                                             input logic [15:0] wdata);
    logic [31:0] f;
    f = '0;
    f[FR_ST_LSB   +: 2]  = ST_CODE;
    f[FR_OP_LSB   +: 2]  = is_write ? OP_WRITE : OP_READ;
    f[FR_PHY_LSB  +: 5]  = phy;
    f[FR_REG_LSB  +: 5]  = regad;
    f[FR_TA_LSB   +: 2]  = is_write ? TA_WRITE : TA_READ;
    f[FR_DATA_LSB +: 16] = is_write ? wdata : 16'h0000;
    return f;
  endfunction

endpackage

// File: rtl/mdio_arbiter_if.sv
// Requester and MDIO-controller signals seen by the arbiter.
interface mdio_arbiter_if;

  logic        REQ0, REQ1;
  logic        OP0, OP1;
  logic [4:0]  PHY0, PHY1;
  logic [4:0]  REG0, REG1;
  logic [15:0] WDATA0, WDATA1;
  logic        GNT0, GNT1;
  logic        DONE0, DONE1;
  logic [15:0] RDATA;
  logic        ERR;
  logic        BUSY;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_DONE;
  logic [15:0] RD_DATA;

  modport slave (
    input  REQ0, REQ1, OP0, OP1, PHY0, PHY1, REG0, REG1, WDATA0, WDATA1,
    input  MDIO_DONE, RD_DATA,
    output GNT0, GNT1, DONE0, DONE1, RDATA, ERR, BUSY, MDIO_START, T_DATA
  );

  modport master (
    output REQ0, REQ1, OP0, OP1, PHY0, PHY1, REG0, REG1, WDATA0, WDATA1,
    output MDIO_DONE, RD_DATA,
    input  GNT0, GNT1, DONE0, DONE1, RDATA, ERR, BUSY, MDIO_START, T_DATA
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; LAST holds the most recently served requester.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       upd_i,
  input  logic       owner_i,
  output logic [1:0] sel_o
);

  logic last_q, last_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = owner_i;

    sel_o = '0;
    if (req0_i && req1_i) sel_o = last_q ? 2'b01 : 2'b10;
    else if (req0_i)      sel_o = 2'b01;
    else if (req1_i)      sel_o = 2'b10;
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one MDIO controller between two requesters: arbitration, frame packing,
// start/done handshake and a per-transaction timeout.
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter int unsigned TO_W           = 12
) (
  input  logic          CLK,
  input  logic          RESET,
  mdio_arbiter_if.slave bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  mdio_state_e     state_q, state_d;
  logic            owner_q, owner_d;
  logic            wr_q, wr_d;
  logic [31:0]     tdata_q, tdata_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [1:0]      sel;
  logic            upd;

  rr_arb2 u_rr (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .req0_i  (bus.REQ0),
    .req1_i  (bus.REQ1),
    .upd_i   (upd),
    .owner_i (owner_q),
    .sel_o   (sel)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      tdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      tdata_q <= tdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    tdata_d = tdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    upd     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|sel) begin
          owner_d = sel[1];
          wr_d    = sel[1] ? bus.OP1 : bus.OP0;
          tdata_d = sel[1] ? pack_frame(bus.OP1, bus.PHY1, bus.REG1, bus.WDATA1)
                           : pack_frame(bus.OP0, bus.PHY0, bus.REG0, bus.WDATA0);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (bus.MDIO_DONE) begin
          if (!wr_q) rdata_d = bus.RD_DATA;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_RESP: begin
        upd     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.MDIO_START = (state_q == ST_ISSUE);
  assign bus.GNT0       = (state_q == ST_ISSUE) && !owner_q;
  assign bus.GNT1       = (state_q == ST_ISSUE) &&  owner_q;
  assign bus.DONE0      = (state_q == ST_RESP)  && !owner_q;
  assign bus.DONE1      = (state_q == ST_RESP)  &&  owner_q;
  assign bus.ERR        = (state_q == ST_RESP)  &&  err_q;
  assign bus.BUSY       = (state_q != ST_IDLE);
  assign bus.T_DATA     = tdata_q;
  assign bus.RDATA      = rdata_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter with issue/response scoreboards.
module tb_mdio_arbiter;

  logic CLK;
  logic RESET;

  mdio_arbiter_if bus ();

  mdio_arbiter #(
    .TIMEOUT_CYCLES (16),
    .TO_W           (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        g1;
    logic [31:0] frame;
  } iss_t;

  typedef struct {
    logic        d1;
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  iss_t        iss_q[$];
  rsp_t        rsp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_txn(input logic who, input logic [31:0] frame, input logic wr,
                            input logic [15:0] ctl_data, input logic err);
    iss_t i;
    rsp_t r;
    i.g1 = who;
    i.frame = frame;
    iss_q.push_back(i);
    if (!wr && !err) exp_rdata = ctl_data;
    r.d1 = who;
    r.rdata = exp_rdata;
    r.err = err;
    rsp_q.push_back(r);
  endtask

  task automatic drive(input logic who, input logic wr, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd);
    if (!who) begin
      bus.REQ0 = 1'b1; bus.OP0 = wr; bus.PHY0 = phy; bus.REG0 = rg; bus.WDATA0 = wd;
    end else begin
      bus.REQ1 = 1'b1; bus.OP1 = wr; bus.PHY1 = phy; bus.REG1 = rg; bus.WDATA1 = wd;
    end
  endtask

  task automatic wait_issue(input string tag);
    iss_t e;
    int n = 0;
    while (bus.MDIO_START !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, bus.MDIO_START, 1);
    chk({tag, "_sb_iss"}, (iss_q.size() > 0), 1);
    if (iss_q.size() > 0) begin
      e = iss_q.pop_front();
      chk({tag, "_gnt0"}, bus.GNT0, !e.g1);
      chk({tag, "_gnt1"}, bus.GNT1, e.g1);
      chk({tag, "_tdata"}, bus.T_DATA, e.frame);
    end
  endtask

  task automatic wait_done(input string tag);
    rsp_t e;
    int n = 0;
    while (bus.DONE0 !== 1'b1 && bus.DONE1 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, (bus.DONE0 | bus.DONE1), 1);
    chk({tag, "_sb_rsp"}, (rsp_q.size() > 0), 1);
    if (rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      chk({tag, "_done0"}, bus.DONE0, !e.d1);
      chk({tag, "_done1"}, bus.DONE1, e.d1);
      chk({tag, "_rdata"}, bus.RDATA, e.rdata);
      chk({tag, "_err"}, bus.ERR, e.err);
    end
  endtask

  task automatic ctl_reply(input int lat, input logic [15:0] d);
    repeat (lat) tick();
    bus.MDIO_DONE = 1'b1;
    bus.RD_DATA = d;
    tick();
    bus.MDIO_DONE = 1'b0;
    bus.RD_DATA = '0;
  endtask

  initial begin
    int n;
    int nd;
    RESET = 1'b0;
    bus.REQ0 = 0; bus.REQ1 = 0; bus.OP0 = 0; bus.OP1 = 0;
    bus.PHY0 = '0; bus.PHY1 = '0; bus.REG0 = '0; bus.REG1 = '0;
    bus.WDATA0 = '0; bus.WDATA1 = '0; bus.MDIO_DONE = 0; bus.RD_DATA = '0;
    exp_rdata = '0;

    // Reset
    repeat (3) tick();
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_start", bus.MDIO_START, 0);
    chk("rst_gnt", {bus.GNT0, bus.GNT1}, 0);
    chk("rst_done", {bus.DONE0, bus.DONE1}, 0);
    chk("rst_err", bus.ERR, 0);
    chk("rst_tdata", bus.T_DATA, 0);
    chk("rst_rdata", bus.RDATA, 0);
    RESET = 1'b1;
    tick();
    chk("rel_busy", bus.BUSY, 0);

    // Single read by requester 0
    drive(0, 0, 5'h01, 5'h02, 16'h0000);
    expect_txn(0, 32'h6088_0000, 0, 16'h8FF1, 0);
    wait_issue("rd");
    bus.REQ0 = 0;
    ctl_reply(3, 16'h8FF1);
    wait_done("rd");
    tick();
    chk("rd_idle", bus.BUSY, 0);

    // Single write by requester 1; RDATA must keep the last read value
    drive(1, 1, 5'h1F, 5'h00, 16'hA5A5);
    expect_txn(1, 32'h5F82_A5A5, 1, 16'h1234, 0);
    wait_issue("wr");
    bus.REQ1 = 0;
    ctl_reply(2, 16'h1234);
    wait_done("wr");
    tick();
    chk("wr_idle", bus.BUSY, 0);

    // Contention: both held, LAST=1 so order is 0,1,0,1
    drive(0, 0, 5'h03, 5'h04, 16'h0000);
    drive(1, 1, 5'h07, 5'h09, 16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_txn(0, 32'h6190_0000, 0, 16'h1111 * (k + 1), 0);
      else            expect_txn(1, 32'h53A6_BEEF, 1, 16'h7777, 0);
      wait_issue($sformatf("cont%0d", k));
      ctl_reply(2, (k % 2 == 0) ? 16'h1111 * (k + 1) : 16'h7777);
      wait_done($sformatf("cont%0d", k));
      if (k == 3) begin
        bus.REQ0 = 0;
        bus.REQ1 = 0;
      end
      tick();
      chk($sformatf("cont%0d_gap", k), bus.BUSY, 0);
    end

    // Timeout: no MDIO_DONE, DONE with ERR after 16 WAIT cycles
    drive(0, 0, 5'h02, 5'h03, 16'h0000);
    expect_txn(0, 32'h610C_0000, 0, 16'h0000, 1);
    wait_issue("to");
    bus.REQ0 = 0;
    tick();
    n = 0;
    while (bus.DONE0 !== 1'b1 && bus.DONE1 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", n, 16);
    wait_done("to");
    tick();
    bus.MDIO_DONE = 1'b1;
    bus.RD_DATA = 16'hDEAD;
    tick();
    bus.MDIO_DONE = 1'b0;
    bus.RD_DATA = '0;
    chk("late_busy", bus.BUSY, 0);
    chk("late_done", {bus.DONE0, bus.DONE1}, 0);
    chk("late_rdata", bus.RDATA, exp_rdata);
    tick();
    chk("late_busy2", bus.BUSY, 0);

    // Reset in the middle of WAIT aborts without a DONE
    drive(0, 1, 5'h04, 5'h05, 16'h1234);
    begin
      iss_t i;
      i.g1 = 0;
      i.frame = 32'h5216_1234;
      iss_q.push_back(i);
    end
    wait_issue("abrt");
    bus.REQ0 = 0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk("abrt_busy", bus.BUSY, 0);
    chk("abrt_done", {bus.DONE0, bus.DONE1}, 0);
    chk("abrt_rdata", bus.RDATA, 0);
    RESET = 1'b1;
    exp_rdata = '0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.DONE0 === 1'b1 || bus.DONE1 === 1'b1) nd++;
    end
    chk("abrt_nodone", nd, 0);

    drive(0, 0, 5'h01, 5'h02, 16'h0000);
    expect_txn(0, 32'h6088_0000, 0, 16'h4321, 0);
    wait_issue("post");
    bus.REQ0 = 0;
    ctl_reply(1, 16'h4321);
    wait_done("post");
    tick();
    chk("post_idle", bus.BUSY, 0);

    chk("sb_empty", iss_q.size() + rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
